// File: rtl/dedos_pkg.sv
// dedos_pkg: shared states, canonical finger patterns and command decoding
// for the finger-gesture encoder.
package dedos_pkg;

    typedef enum logic [1:0] {REPOSO, MOVER, MANTENER} estado_t;

    localparam logic [3:0] PATRON_REPOSO = 4'b0000;
    localparam logic [3:0] PATRON_DOS    = 4'b0011;
    localparam logic [3:0] PATRON_TRES   = 4'b0111;
    localparam logic [3:0] PATRON_MANO   = 4'b1111;

    function automatic logic [3:0] comando_a_patron(input logic [1:0] c);
        return c == 2'b00 ? PATRON_REPOSO :
               c == 2'b01 ? PATRON_DOS    :
               c == 2'b10 ? PATRON_TRES   : PATRON_MANO;
    endfunction

endpackage

// File: rtl/temporizador_dedos.sv
// temporizador_dedos: loadable down-counter with zero flag, shared by the
// finger-step and pose-hold phases.
module temporizador_dedos #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         carga,
    input  logic         dec,
    input  logic [W-1:0] valor,
    output logic         cero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (carga)
            cnt <= valor;
        else if (dec && cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign cero = cnt == '0;

endmodule

// File: rtl/codificador_dedos.sv
// codificador_dedos: drives the finger actuators toward the pattern of an
// accepted gesture command, one finger per step, then holds the pose.
module codificador_dedos
    import dedos_pkg::*;
#(
    parameter int CICLOS_PASO     = 4,
    parameter int CICLOS_MANTENER = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] comando,
    input  logic       comando_valido,
    input  logic       paro,
    output logic       listo,
    output logic [3:0] dedos,
    output logic       ocupado,
    output logic       hecho
);

    localparam int MAXC = CICLOS_PASO > CICLOS_MANTENER ? CICLOS_PASO : CICLOS_MANTENER;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] RECARGA_PASO     = CW'(CICLOS_PASO - 1);
    localparam logic [CW-1:0] RECARGA_MANTENER = CW'(CICLOS_MANTENER - 1);

    estado_t       estado, estado_n;
    logic [3:0]    target, target_n, dedos_n, diff;
    logic          hecho_n, carga, dec, clr, cero;
    logic [CW-1:0] valor;

    temporizador_dedos #(.W(CW)) u_temporizador (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .carga (carga),
        .dec   (dec),
        .valor (valor),
        .cero  (cero)
    );

    assign diff    = dedos ^ target;
    assign listo   = estado == REPOSO;
    assign ocupado = !listo;

    always_comb begin
        estado_n = estado;
        dedos_n  = dedos;
        target_n = target;
        hecho_n  = 1'b0;
        carga    = 1'b0;
        dec      = 1'b0;
        clr      = 1'b0;
        valor    = RECARGA_PASO;
        if (paro) begin
            estado_n = REPOSO;
            dedos_n  = PATRON_REPOSO;
            clr      = 1'b1;
        end else begin
            case (estado)
                REPOSO: if (comando_valido) begin
                    target_n = comando_a_patron(comando);
                    estado_n = MOVER;
                    carga    = 1'b1;
                end
                MOVER: if (diff == 4'b0000) begin
                    estado_n = MANTENER;
                    valor    = RECARGA_MANTENER;
                    carga    = 1'b1;
                end else if (cero) begin
                    // two's-complement trick isolates the lowest differing finger
                    dedos_n = dedos ^ (diff & (~diff + 4'd1));
                    carga   = 1'b1;
                end else begin
                    dec = 1'b1;
                end
                MANTENER: if (cero) begin
                    estado_n = REPOSO;
                    hecho_n  = 1'b1;
                end else begin
                    dec = 1'b1;
                end
                default: estado_n = REPOSO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= REPOSO;
            dedos  <= PATRON_REPOSO;
            target <= PATRON_REPOSO;
            hecho  <= 1'b0;
        end else begin
            estado <= estado_n;
            dedos  <= dedos_n;
            target <= target_n;
            hecho  <= hecho_n;
        end
    end

endmodule

// File: tb/tb_codificador_dedos.sv
// tb_codificador_dedos: table-driven commands with a scoreboard of expected
// finger changes, plus hand sequences for ignore, stop and async reset.
module tb_codificador_dedos;

    localparam int P = 4;
    localparam int M = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] comando = 2'b00;
    logic       comando_valido = 1'b0;
    logic       paro = 1'b0;
    logic       listo, ocupado, hecho;
    logic [3:0] dedos;

    codificador_dedos #(.CICLOS_PASO(P), .CICLOS_MANTENER(M)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .comando        (comando),
        .comando_valido (comando_valido),
        .paro           (paro),
        .listo          (listo),
        .dedos          (dedos),
        .ocupado        (ocupado),
        .hecho          (hecho)
    );

    always #5 clk = ~clk;

    typedef struct {logic [3:0] pat; int edge_n;} ev_t;
    typedef struct {logic [1:0] cmd; int hecho_edge;} vec_t;

    ev_t        q[$];
    vec_t       tabla[5];
    logic [3:0] modelo = 4'b0000;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input bit ok, input string nombre, input int act, input int esp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, esp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] patron(input logic [1:0] c);
        case (c)
            2'b00:   return 4'b0000;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic run_cmd(input logic [1:0] cmd, input int hecho_edge, input bit hold);
        logic [3:0] cur, tgt, prev;
        int k;
        bit done;
        ev_t ev;
        tgt = patron(cmd);
        cur = modelo;
        k = 0;
        for (int b = 0; b < 4; b++)
            if (cur[b] != tgt[b]) begin
                cur[b] = tgt[b];
                k++;
                q.push_back('{pat: cur, edge_n: k * P});
            end
        comando = cmd;
        comando_valido = 1'b1;
        tick();
        if (hold) comando = 2'b00;
        else comando_valido = 1'b0;
        chk(!listo && ocupado, "aceptar", listo, 0);
        chk(!hecho, "hecho_unico", hecho, 0);
        prev = dedos;
        done = 1'b0;
        for (int e = 1; e <= 200 && !done; e++) begin
            tick();
            if (dedos !== prev) begin
                if (q.size() == 0) chk(1'b0, "cambio_extra", dedos, prev);
                else begin
                    ev = q.pop_front();
                    chk(dedos === ev.pat, "patron", dedos, ev.pat);
                    chk(e == ev.edge_n, "flanco_cambio", e, ev.edge_n);
                end
                prev = dedos;
            end
            if (hecho) begin
                done = 1'b1;
                chk(e == hecho_edge, "flanco_hecho", e, hecho_edge);
                chk(listo && !ocupado, "listo_en_hecho", listo, 1);
                chk(dedos === tgt, "pose_final", dedos, tgt);
            end
        end
        if (!done) chk(1'b0, "timeout_hecho", 0, 1);
        chk(q.size() == 0, "cambios_faltantes", q.size(), 0);
        q.delete();
        modelo = tgt;
    endtask

    initial begin
        bit visto;
        tabla[0] = '{2'b11, 25};
        tabla[1] = '{2'b01, 17};
        tabla[2] = '{2'b01, 9};
        tabla[3] = '{2'b10, 13};
        tabla[4] = '{2'b00, 21};

        #2;
        chk(dedos === 4'b0000, "reset_dedos", dedos, 0);
        chk(listo === 1'b1 && ocupado === 1'b0, "reset_listo", listo, 1);
        chk(hecho === 1'b0, "reset_hecho", hecho, 0);
        #10 rst_n = 1'b1;
        tick();

        foreach (tabla[i]) run_cmd(tabla[i].cmd, tabla[i].hecho_edge, 1'b0);

        // valid stays high with 00 during the move: ignored, then taken in the hecho cycle
        run_cmd(2'b11, 25, 1'b1);
        run_cmd(2'b00, 25, 1'b0);

        comando = 2'b11;
        comando_valido = 1'b1;
        tick();
        comando_valido = 1'b0;
        repeat (4) tick();
        chk(dedos === 4'b0001, "paro_previo", dedos, 1);
        tick();
        paro = 1'b1;
        comando = 2'b10;
        comando_valido = 1'b1;
        tick();
        paro = 1'b0;
        comando_valido = 1'b0;
        chk(dedos === 4'b0000, "paro_dedos", dedos, 0);
        chk(listo === 1'b1 && ocupado === 1'b0, "paro_listo", listo, 1);
        chk(hecho === 1'b0, "paro_hecho", hecho, 0);
        tick();
        chk(listo === 1'b1, "paro_sin_aceptar", listo, 1);
        visto = 1'b0;
        repeat (20) begin
            tick();
            visto |= hecho;
        end
        chk(!visto, "hecho_tras_paro", visto, 0);
        modelo = 4'b0000;
        run_cmd(2'b01, 17, 1'b0);

        comando = 2'b11;
        comando_valido = 1'b1;
        tick();
        comando_valido = 1'b0;
        repeat (11) tick();
        chk(ocupado === 1'b1 && dedos === 4'b1111, "mantener_previo", dedos, 15);
        #3 rst_n = 1'b0;
        #1;
        chk(dedos === 4'b0000, "rst_async_dedos", dedos, 0);
        chk(listo === 1'b1 && ocupado === 1'b0, "rst_async_listo", listo, 1);
        chk(hecho === 1'b0, "rst_async_hecho", hecho, 0);
        #2 rst_n = 1'b1;
        modelo = 4'b0000;
        run_cmd(2'b10, 21, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
